// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined minifloat multiplier.
// Pack helpers return 32-bit words; callers slice to their own width.
package fp_mul_pkg;

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF} op_class_e;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [31:0] pack_inf(input int exp_w, input int man_w, input logic sgn);
    return (32'(sgn) << (exp_w + man_w)) | (((32'd1 << exp_w) - 32'd1) << man_w);
  endfunction

  // Canonical NaN: positive, all-ones exponent, mantissa MSB set.
  function automatic logic [31:0] pack_nan(input int exp_w, input int man_w);
    return pack_inf(exp_w, man_w, 1'b0) | (32'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final stage of the multiplier: normalise, round-to-nearest-even,
// range check, special-value override and packing. Purely combinational.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 3,
  parameter  int MAN_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W,
  localparam int P     = 2 * MAN_W + 2
) (
  input  logic                    sgn,
  input  op_class_e               cls_a,
  input  op_class_e               cls_b,
  input  logic signed [EXP_W+1:0] esum,
  input  logic [P-1:0]            prod,
  output logic [W-1:0]            result,
  output logic [3:0]              flags
);

  localparam logic signed [EXP_W+1:0] E_MAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic [P-1:0]            norm;
  logic [MAN_W-1:0]        mant;
  logic                    guard, sticky, rnd_up, ovf, unf;
  logic [MAN_W:0]          mant_r;
  logic signed [EXP_W+1:0] e_fin;

  // Leading one always lands in norm[P-1]; product is in [1,4).
  assign norm   = prod[P-1] ? prod : prod << 1;
  assign mant   = norm[P-2 -: MAN_W];
  assign guard  = norm[MAN_W];
  assign sticky = |norm[MAN_W-1:0];
  assign rnd_up = guard & (sticky | mant[0]);
  // On carry-out the low MAN_W bits are already zero (1.11..1 + ulp = 10.00..0).
  assign mant_r = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
  assign e_fin  = esum + (EXP_W+2)'(prod[P-1]) + (EXP_W+2)'(mant_r[MAN_W]);
  assign ovf    = !e_fin[EXP_W+1] && (e_fin >= E_MAX);
  assign unf    = e_fin[EXP_W+1] || (e_fin == '0);

  always_comb begin
    result = '0;
    flags  = '0;
    if ((cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO)) begin
      result             = W'(pack_nan(EXP_W, MAN_W));
      flags[FLG_INVALID] = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      result = W'(pack_inf(EXP_W, MAN_W, sgn));
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      result = {sgn, {(W-1){1'b0}}};
    end else if (ovf) begin
      result              = W'(pack_inf(EXP_W, MAN_W, sgn));
      flags[FLG_OVERFLOW] = 1'b1;
      flags[FLG_INEXACT]  = 1'b1;
    end else if (unf) begin
      result               = {sgn, {(W-1){1'b0}}};
      flags[FLG_UNDERFLOW] = 1'b1;
      flags[FLG_INEXACT]   = 1'b1;
    end else begin
      result             = {sgn, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
      flags[FLG_INEXACT] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined minifloat multiplier with valid/ready streaming.
// All stages advance together; a stalled output freezes the whole pipe.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 3,
  parameter  int MAN_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int STAGES = 3;
  localparam int P      = 2 * MAN_W + 2;
  localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(bias(EXP_W));

  function automatic op_class_e classify(input logic [EXP_W-1:0] e);
    if (e == '0) return CLS_ZERO;
    if (e == '1) return CLS_INF;
    return CLS_NORM;
  endfunction

  logic [STAGES:1]         vld_q;
  logic [STAGES:0]         vld_pipe;
  logic                    advance;

  logic                    s1_sgn, s2_sgn;
  op_class_e               s1_cls_a, s1_cls_b, s2_cls_a, s2_cls_b;
  logic signed [EXP_W+1:0] s1_esum, s2_esum;
  logic [MAN_W-1:0]        s1_ma, s1_mb;
  logic [P-1:0]            s2_prod;
  logic [W-1:0]            rnd_result;
  logic [3:0]              rnd_flags;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_q[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      result <= '0;
      flags  <= '0;
    end else if (advance) begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (vld_pipe[STAGES-1]) begin
        result <= rnd_result;
        flags  <= rnd_flags;
      end
    end
  end

  // Datapath registers carry no reset; their contents are qualified by vld_q.
  always_ff @(posedge clk) begin
    if (advance && vld_pipe[0]) begin
      s1_sgn   <= a[W-1] ^ b[W-1];
      s1_cls_a <= classify(a[W-2 -: EXP_W]);
      s1_cls_b <= classify(b[W-2 -: EXP_W]);
      s1_esum  <= $signed({2'b00, a[W-2 -: EXP_W]}) + $signed({2'b00, b[W-2 -: EXP_W]}) - BIAS_E;
      s1_ma    <= a[MAN_W-1:0];
      s1_mb    <= b[MAN_W-1:0];
    end
    if (advance && vld_pipe[1]) begin
      s2_sgn   <= s1_sgn;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_esum  <= s1_esum;
      s2_prod  <= P'({1'b1, s1_ma}) * P'({1'b1, s1_mb});
    end
  end

  fp_mul_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sgn    (s2_sgn),
    .cls_a  (s2_cls_a),
    .cls_b  (s2_cls_b),
    .esum   (s2_esum),
    .prod   (s2_prod),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed table plus stream/back-pressure/reset sequences for fp_mul_pipe,
// at the 8-bit default format and at a 16-bit (5/10) format.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, result;
  logic [3:0]  flags;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  flags16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .result(result16), .flags(flags16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, quotient/remainder rounding against half-ulp.
  function automatic logic [19:0] ref_mul(input int E, input int M, input logic [15:0] x, input logic [15:0] y);
    int emax, bs, ex, ey, sh, e;
    logic s;
    logic zx, zy, ix, iy;
    longint sig, q, rem, half, one;
    logic [15:0] r;
    logic [3:0] f;
    one  = 1;
    emax = (1 << E) - 1;
    bs   = (1 << (E - 1)) - 1;
    s    = x[E+M] ^ y[E+M];
    ex   = int'(x >> M) & emax;
    ey   = int'(y >> M) & emax;
    zx = (ex == 0); zy = (ey == 0); ix = (ex == emax); iy = (ey == emax);
    r = '0; f = '0;
    if ((zx && iy) || (ix && zy)) begin
      r = 16'((emax << M) | (1 << (M - 1)));
      f = 4'b1000;
    end else if (ix || iy) begin
      r = 16'((int'(s) << (E + M)) | (emax << M));
    end else if (zx || zy) begin
      r = 16'(int'(s) << (E + M));
    end else begin
      sig = ((longint'(x) & ((one << M) - 1)) + (one << M)) *
            ((longint'(y) & ((one << M) - 1)) + (one << M));
      sh   = (sig >= (one << (2 * M + 1))) ? M + 1 : M;
      q    = sig >> sh;
      rem  = sig - (q << sh);
      half = one << (sh - 1);
      e    = ex + ey - bs + sh - M;
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (one << (M + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= emax) begin
        r = 16'((int'(s) << (E + M)) | (emax << M));
        f = 4'b0101;
      end else if (e <= 0) begin
        r = 16'(int'(s) << (E + M));
        f = 4'b0011;
      end else begin
        r = 16'((int'(s) << (E + M)) | (e << M) | int'(q - (one << M)));
        f = {3'b000, rem != 0};
      end
    end
    return {f, r};
  endfunction

  task automatic run_one(input logic [7:0] ia, input logic [7:0] ib,
                         output logic [7:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = result;
    f = flags;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  r;
    logic [3:0]  f;
    int          lat, extra, sent, got, cyc;
    logic [7:0]  pa[8], pb[8];
    logic [15:0] qa[12], qb[12];
    logic [19:0] e20;
    logic [11:0] exp_q[$];
    logic [19:0] exp16_q[$];
    logic [11:0] e12;

    vecs[0]  = '{8'h38, 8'h38, 8'h42, 4'h0};
    vecs[1]  = '{8'hB8, 8'h38, 8'hC2, 4'h0};
    vecs[2]  = '{8'h31, 8'h31, 8'h32, 4'h1};
    vecs[3]  = '{8'h6F, 8'h6F, 8'h70, 4'h5};
    vecs[4]  = '{8'h10, 8'h10, 8'h00, 4'h3};
    vecs[5]  = '{8'h70, 8'h00, 8'h78, 4'h8};
    vecs[6]  = '{8'h80, 8'h38, 8'h80, 4'h0};
    vecs[7]  = '{8'hF0, 8'h38, 8'hF0, 4'h0};
    vecs[8]  = '{8'h30, 8'h30, 8'h30, 4'h0};
    vecs[9]  = '{8'h20, 8'hA0, 8'h90, 4'h0};
    vecs[10] = '{8'h00, 8'hF0, 8'h78, 4'h8};
    vecs[11] = '{8'hF0, 8'hF0, 8'h70, 4'h0};
    vecs[12] = '{8'hB8, 8'h90, 8'h18, 4'h0};
    vecs[13] = '{8'h33, 8'h33, 8'h37, 4'h1};
    vecs[14] = '{8'h37, 8'h36, 8'h40, 4'h1};
    vecs[15] = '{8'h38, 8'h31, 8'h3A, 4'h1};
    vecs[16] = '{8'h38, 8'h33, 8'h3C, 4'h1};
    vecs[17] = '{8'h58, 8'h50, 8'h70, 4'h5};
    vecs[18] = '{8'h20, 8'h20, 8'h10, 4'h0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_one(vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].flg));
    end

    // Reset with three operations in flight and the output stalled.
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; a = 8'h38; b = 8'h38;
    @(posedge clk); @(negedge clk); a = 8'h31; b = 8'h31;
    @(posedge clk); @(negedge clk); a = 8'h6F; b = 8'h6F;
    @(posedge clk); @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    check("midreset flags", 32'(flags), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    run_one(8'h31, 8'h31, r, f, lat);
    check("post-reset latency", 32'(lat), 32'd3);
    check("post-reset result", 32'(r), 32'h32);
    check("post-reset flags", 32'(f), 32'h1);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("post-reset stray outputs", 32'(extra), 32'd0);

    // Random stream with pseudo-random back-pressure.
    for (int i = 0; i < 8; i++) begin
      pa[i] = 8'($urandom_range(0, 255));
      pb[i] = 8'($urandom_range(0, 255));
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      in_valid  = (sent < 8);
      a         = pa[sent % 8];
      b         = pb[sent % 8];
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("bp in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (in_valid && in_ready) begin
        e20 = ref_mul(3, 4, {8'h00, a}, {8'h00, b});
        exp_q.push_back({e20[19:16], e20[7:0]});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp unexpected output", 32'(result), 32'hFFFF_FFFF);
        end else begin
          e12 = exp_q.pop_front();
          check($sformatf("bp result #%0d", got), 32'({flags, result}), 32'(e12));
        end
        got++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp outputs received", 32'(got), 32'd8);
    check("bp scoreboard empty", 32'(exp_q.size()), 32'd0);

    // 16-bit format: hand-computed tie case first, then random normals.
    qa[0] = 16'h3C01; qb[0] = 16'h3E00;
    for (int i = 1; i < 12; i++) begin
      qa[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
      qb[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 12 && cyc < 300) begin
      @(negedge clk);
      in_valid16  = (sent < 12);
      a16         = qa[sent % 12];
      b16         = qb[sent % 12];
      out_ready16 = 1'b1;
      #1;
      if (in_valid16 && in_ready16) begin
        exp16_q.push_back(sent == 0 ? 20'h1_3E02 : ref_mul(5, 10, a16, b16));
        sent++;
      end
      if (out_valid16) begin
        if (exp16_q.size() == 0) begin
          check("fp16 unexpected output", 32'(result16), 32'hFFFF_FFFF);
        end else begin
          e20 = exp16_q.pop_front();
          check($sformatf("fp16 result #%0d", got), 32'({flags16, result16}), 32'(e20));
        end
        got++;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    check("fp16 outputs received", 32'(got), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
